// File: rtl/bell_round_ctrl.sv
// bell_round_ctrl -- round sequencer for the two-player bell game.
//   Deals a card pair from a 16-bit LFSR and opens a timed bell window. The first
//   bell press wins arbitration. The hand is judged, and a one-cycle packed score
//   delta is emitted for score_file. The block then watches the running totals for
//   a winning margin.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   keypad_in, key_valid     keypad code + one-cycle strobe
//                            (0101 start, 0111 P1 bell, 1001 P2 bell)
//   scoreA, scoreB           running totals from score_file
//   c1, c2, n1, n2           current hand (colour 0..3, number 1..5)
//   card_valid               hand open for pressing
//   add_score                {deltaB, deltaA}; nonzero only in the award cycle
//   who                      01 P1 / 10 P2 / 00 none
//   finish, winner           game over (sticky), 01 A / 10 B
// Optional build macro BELL_DBG_CARD_EN adds two inputs:
//   dbg_load                 take the next hand from dbg_card instead of the LFSR
//   dbg_card                 {c2,n2,c1,n1}
module bell_round_ctrl #(
  parameter logic [15:0] WINDOW_CYC  = 16'd2000,
  parameter logic [15:0] TICK_CYC    = 16'd100,
  parameter logic [7:0]  BONUS_MAX   = 8'd10,
  parameter logic [15:0] LOCKOUT_CYC = 16'd50,
  parameter logic [8:0]  WIN_MARGIN  = 9'd50,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  keypad_in,
  input  logic        key_valid,
  input  logic [8:0]  scoreA,
  input  logic [8:0]  scoreB,
`ifdef BELL_DBG_CARD_EN
  input  logic        dbg_load,
  input  logic [9:0]  dbg_card,
`endif
  output logic [1:0]  c1,
  output logic [1:0]  c2,
  output logic [2:0]  n1,
  output logic [2:0]  n2,
  output logic        card_valid,
  output logic [15:0] add_score,
  output logic [1:0]  who,
  output logic        finish,
  output logic [1:0]  winner
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEAL, S_OPEN, S_JUDGE, S_AWARD, S_SETTLE, S_CHECK, S_LOCK, S_OVER
  } state_t;

  state_t      state, nxt;
  logic [15:0] lfsr, lfsr_nxt;
  logic [15:0] cnt;    // window counter in OPEN, lockout counter in LOCK
  logic [15:0] tick;
  logic [7:0]  bonus;

  logic        start, p1, p2, press, right, a_wins, b_wins;
  logic        use_dbg;
  logic [9:0]  dbg_cards;
  logic [7:0]  pts_press, pts_other;
  logic [15:0] delta;

  // LFSR value 5..7 folds back onto 1..3 so every number stays in 1..5.
  function automatic logic [2:0] card_num(input logic [2:0] v);
    return (v <= 3'd4) ? v + 3'd1 : v - 3'd4;
  endfunction

`ifdef BELL_DBG_CARD_EN
  assign use_dbg   = dbg_load;
  assign dbg_cards = dbg_card;
`else
  assign use_dbg   = 1'b0;
  assign dbg_cards = 10'd0;
`endif

  assign card_valid = (state == S_OPEN);

  always_comb begin
    start    = key_valid && (keypad_in == 4'b0101);
    p1       = key_valid && (keypad_in == 4'b0111);
    p2       = key_valid && (keypad_in == 4'b1001);
    press    = p1 || p2;
    lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    right    = (c1 == c2) ? (({1'b0, n1} + {1'b0, n2}) == 4'd5)
                          : (n1 == 3'd5 || n2 == 3'd5);
    // Widen to 10 bits so scoreB + margin cannot wrap.
    a_wins   = {1'b0, scoreA} > ({1'b0, scoreB} + {1'b0, WIN_MARGIN});
    b_wins   = {1'b0, scoreB} > ({1'b0, scoreA} + {1'b0, WIN_MARGIN});
    pts_press = right ? bonus : 8'hFF;
    pts_other = right ? 8'h00 : 8'h01;
    delta     = (who == 2'b01) ? {pts_other, pts_press} : {pts_press, pts_other};

    nxt = state;
    case (state)
      S_IDLE:   if (start) nxt = S_DEAL;
      S_DEAL:   nxt = S_OPEN;
      S_OPEN:   if (press) nxt = S_JUDGE;                   // press beats expiry
                else if (cnt == WINDOW_CYC - 16'd1) nxt = S_DEAL;
      S_JUDGE:  nxt = S_AWARD;
      S_AWARD:  nxt = S_SETTLE;
      S_SETTLE: nxt = S_CHECK;
      S_CHECK:  nxt = (a_wins || b_wins) ? S_OVER : S_LOCK;
      S_LOCK:   if (cnt == LOCKOUT_CYC - 16'd1) nxt = S_DEAL;
      S_OVER:   nxt = S_OVER;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      lfsr      <= LFSR_SEED;
      cnt       <= 16'd0;
      tick      <= 16'd0;
      bonus     <= 8'd0;
      c1        <= 2'd0;
      c2        <= 2'd0;
      n1        <= 3'd0;
      n2        <= 3'd0;
      add_score <= 16'd0;
      who       <= 2'b00;
      finish    <= 1'b0;
      winner    <= 2'b00;
    end else begin
      state     <= nxt;
      add_score <= 16'd0;
      case (state)
        S_DEAL: begin
          if (use_dbg) begin
            {c2, n2, c1, n1} <= dbg_cards;
          end else begin
            lfsr <= lfsr_nxt;
            c1   <= lfsr_nxt[1:0];
            n1   <= card_num(lfsr_nxt[4:2]);
            c2   <= lfsr_nxt[6:5];
            n2   <= card_num(lfsr_nxt[9:7]);
          end
          bonus <= BONUS_MAX;
          cnt   <= 16'd0;
          tick  <= 16'd0;
        end
        S_OPEN: begin
          cnt <= cnt + 16'd1;
          if (tick == TICK_CYC - 16'd1) begin
            tick <= 16'd0;
            if (bonus > 8'd1) bonus <= bonus - 8'd1;
          end else begin
            tick <= tick + 16'd1;
          end
          if (press) who <= p1 ? 2'b01 : 2'b10;
        end
        // Registered here so the delta is visible exactly during AWARD.
        S_JUDGE: add_score <= delta;
        S_CHECK: begin
          cnt <= 16'd0;
          if (a_wins) begin
            winner <= 2'b01;
            finish <= 1'b1;
          end else if (b_wins) begin
            winner <= 2'b10;
            finish <= 1'b1;
          end
        end
        S_LOCK: begin
          cnt <= cnt + 16'd1;
          if (cnt == LOCKOUT_CYC - 16'd1) who <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bell_round_ctrl.sv
// Bench for bell_round_ctrl: a game-level model (LFSR, card mapping, judging, bonus
// timing) predicts each hand and every score delta. Deltas go through a scoreboard
// checked against add_score whenever it is nonzero.
module tb_bell_round_ctrl;
  localparam logic [3:0] K_START = 4'b0101, K_P1 = 4'b0111, K_P2 = 4'b1001;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0, rst;
  logic [3:0]  keypad_in;
  logic        key_valid;
  logic [8:0]  scoreA, scoreB;
  logic [1:0]  c1, c2, who, winner;
  logic [2:0]  n1, n2;
  logic        card_valid, finish;
  logic [15:0] add_score;

  bell_round_ctrl dut (
    .clk(clk), .rst(rst), .keypad_in(keypad_in), .key_valid(key_valid),
    .scoreA(scoreA), .scoreB(scoreB),
`ifdef BELL_DBG_CARD_EN
    .dbg_load(1'b0), .dbg_card(10'd0),
`endif
    .c1(c1), .c2(c2), .n1(n1), .n2(n2), .card_valid(card_valid),
    .add_score(add_score), .who(who), .finish(finish), .winner(winner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [15:0] val; int cyc; } sb_t;
  sb_t sb[$];
  bit  rdy = 0;

  always @(negedge clk) begin
    if (rdy && add_score !== 16'h0) begin
      if (sb.size() == 0) chk("add_spurious", {16'h0, add_score}, 32'h0);
      else begin
        sb_t e;
        e = sb.pop_front();
        chk("add_val", {16'h0, add_score}, {16'h0, e.val});
        chk("add_cyc", cyc, e.cyc);
      end
    end
  end

  // ---- reference model ----
  logic [15:0] m_lfsr;
  logic [1:0]  m_c1, m_c2;
  logic [2:0]  m_n1, m_n2;

  function automatic logic [2:0] fnum(input logic [2:0] v);
    return (v < 3'd5) ? v + 3'd1 : v - 3'd4;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic key(input logic [3:0] code);
    keypad_in = code; key_valid = 1'b1;
    tick(1);
    key_valid = 1'b0; keypad_in = 4'h0;
  endtask

  // Called one cycle into OPEN: steps the model LFSR and checks the new hand.
  task automatic open_hand();
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    m_c1 = m_lfsr[1:0]; m_n1 = fnum(m_lfsr[4:2]);
    m_c2 = m_lfsr[6:5]; m_n2 = fnum(m_lfsr[9:7]);
    chk("hand", {22'h0, c1, n1, c2, n2}, {22'h0, m_c1, m_n1, m_c2, m_n2});
    chk("card_valid_open", card_valid, 1'b1);
  endtask

  // Press the bell in OPEN cycle k (0 = first open cycle); leaves the DUT in JUDGE.
  task automatic press(input int k, input bit is_p2);
    int       b;
    bit       ok;
    logic [7:0] pp, po;
    sb_t      e;
    tick(k);
    b  = 10 - (k + 1) / 100;
    if (b < 1) b = 1;
    ok = (m_c1 == m_c2) ? (int'(m_n1) + int'(m_n2) == 5) : (m_n1 == 3'd5 || m_n2 == 3'd5);
    pp = ok ? 8'(b) : 8'hFF;
    po = ok ? 8'h00 : 8'h01;
    key(is_p2 ? K_P2 : K_P1);
    e.val = is_p2 ? {pp, po} : {po, pp};
    e.cyc = cyc + 1;
    sb.push_back(e);
    chk("who_latch", who, is_p2 ? 2'b10 : 2'b01);
  endtask

  // From JUDGE (+off edges already used): ride through LOCK into the next hand.
  task automatic tail(input logic [1:0] w, input int off);
    tick(5 - off);
    key(K_P2);                       // ignored during lockout
    chk("lock_who_hold", who, w);
    chk("lock_no_finish", finish, 1'b0);
    tick(47);
    chk("lock_who_end", who, w);
    tick(1);
    chk("deal_who_clr", who, 2'b00);
    chk("deal_cv", card_valid, 1'b0);
    tick(1);
    open_hand();
  endtask

  initial begin
    rst = 1'b0; key_valid = 1'b0; keypad_in = 4'h0; scoreA = 9'd0; scoreB = 9'd0;
    m_lfsr = SEED;
    tick(2);
    rdy = 1;
    chk("rst_outs", {15'h0, c1, c2, n1, n2, card_valid, who, finish, winner},  32'h0);
    chk("rst_add", {16'h0, add_score}, 32'h0);
    rst = 1'b1;

    key(K_P1);                       // bell in IDLE does nothing
    tick(2);
    chk("idle_cv", card_valid, 1'b0);
    chk("idle_who", who, 2'b00);

    key(K_START); tick(1); open_hand();
    press(320, 1'b0);                // three ticks in: bonus 7 if right
    tail(2'b01, 0);

    press(40, 1'b1);
    key(K_P1);                       // second press of the same window dropped
    chk("p2_keeps", who, 2'b10);
    tail(2'b10, 1);

    scoreA = 9'd120; scoreB = 9'd70; // 120 > 120 false -> continue
    tick(2000);
    chk("expire_cv", card_valid, 1'b0);
    chk("expire_who", who, 2'b00);
    tick(1); open_hand();
    press(1999, 1'b0);               // press on the expiry cycle, bonus floored to 1
    tail(2'b01, 0);

    scoreB = 9'd69;                  // 120 > 119 -> A wins
    press(5, 1'b1);                  // bonus reloaded to 10
    tick(4);
    chk("fin", finish, 1'b1);
    chk("winner_a", winner, 2'b01);
    tick(20);
    key(K_START); tick(3);
    chk("over_cv", card_valid, 1'b0);
    chk("over_fin", finish, 1'b1);

    rst = 1'b0; tick(2); rst = 1'b1;
    chk("rst_fin", {30'h0, finish, winner != 2'b00}, 32'h0);
    m_lfsr = SEED;
    key(K_START); tick(1); open_hand();
    press(10, 1'b0);
    tick(1);                         // AWARD
    rst = 1'b0; tick(1);
    chk("rst_award_add", {16'h0, add_score}, 32'h0);
    chk("rst_award_cv", card_valid, 1'b0);
    chk("rst_award_who", who, 2'b00);
    rst = 1'b1;
    m_lfsr = SEED;
    key(K_START); tick(1); open_hand();

    tick(3);
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
